// File: rtl/ram_pkg.sv
// Shared sizes, FSM states and FIFO entry layout
// for the FMO write-back path.
package ram_pkg;
  localparam int PX_W        = 16;
  localparam int FMO_N_ELEM  = 1024;
  localparam int PX_PER_WORD = 4;
  localparam int EXT_AW      = 32;
  localparam int FIFO_DEPTH  = 2;

  localparam int FMO_AW = $clog2(FMO_N_ELEM);
  localparam int NPX_W  = FMO_AW + 1;
  localparam int LANE_W =
    (PX_PER_WORD > 1) ? $clog2(PX_PER_WORD) : 1;
  localparam int WORD_W = PX_W * PX_PER_WORD;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } wb_state_e;

  typedef struct packed {
    logic [EXT_AW-1:0]      addr;
    logic [WORD_W-1:0]      data;
    logic [PX_PER_WORD-1:0] strb;
  } wb_word_t;
endpackage

// File: rtl/fmo_writeback_if.sv
// External-memory word channel: valid/ready with
// address, packed pixel data and lane strobes.
interface fmo_writeback_if;
  import ram_pkg::*;

  logic                   ext_valid;
  logic                   ext_ready;
  logic [EXT_AW-1:0]      ext_addr;
  logic [WORD_W-1:0]      ext_data;
  logic [PX_PER_WORD-1:0] ext_strb;

  modport master (
    output ext_valid,
    output ext_addr,
    output ext_data,
    output ext_strb,
    input  ext_ready
  );

  modport slave (
    input  ext_valid,
    input  ext_addr,
    input  ext_data,
    input  ext_strb,
    output ext_ready
  );
endinterface

// File: rtl/fmo_wb_fifo.sv
// Small synchronous FIFO of packed output words;
// storage is not reset, emptiness lives in count.
module fmo_wb_fifo
  import ram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_word_t         din,
  input  logic             pop,
  output wb_word_t         dout,
  output logic [CNT_W-1:0] count
);
  localparam int PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wb_word_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout = mem[rp];
endmodule

// File: rtl/fmo_writeback.sv
// Drains the FMO RAM at layer end, packing pixels
// into external words pushed over valid/ready.
module fmo_writeback
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [EXT_AW-1:0] base_addr,
  input  logic [NPX_W-1:0]  n_px,
  output logic [FMO_AW-1:0] fmo_addr,
  output logic              fmo_write,
  input  logic [PX_W-1:0]   fmo_res,
  fmo_writeback_if.master   ext,
  output logic              busy,
  output logic              done
);
  wb_state_e              state;
  wb_state_e              state_n;
  logic [NPX_W-1:0]       n_q;
  logic [NPX_W-1:0]       rd_cnt;
  logic [NPX_W-1:0]       ret_cnt;
  logic [EXT_AW-1:0]      base_q;
  logic [EXT_AW-1:0]      wcnt;
  logic                   rd_valid;
  logic [WORD_W-1:0]      acc;
  logic [WORD_W-1:0]      wdata;
  logic [PX_PER_WORD-1:0] strb;
  logic [LANE_W-1:0]      ret_lane;
  logic                   ret_cmp;
  logic                   cand_cmp;
  logic                   room;
  logic                   issue;
  logic                   pop;
  logic                   drained;
  logic [CNT_W-1:0]       cnt;
  wb_word_t               din;
  wb_word_t               head;

  assign ret_lane = ret_cnt[LANE_W-1:0];
  assign ret_cmp  = rd_valid &&
    (ret_lane == LANE_W'(PX_PER_WORD - 1) ||
     ret_cnt == n_q - NPX_W'(1));
  assign cand_cmp =
    rd_cnt[LANE_W-1:0] == LANE_W'(PX_PER_WORD - 1) ||
    rd_cnt == n_q - NPX_W'(1);
  assign pop = ext.ext_valid && ext.ext_ready;

  // A word-closing read must find a FIFO slot when
  // its pixel returns next cycle.
  assign room =
    (32'(cnt) + 32'(ret_cmp)) <
    (32'(FIFO_DEPTH) + 32'(pop));

  assign drained = !rd_valid && ret_cnt == n_q &&
    (cnt == '0 || (cnt == CNT_W'(1) && pop));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (n_px == '0) ? DONE : READ;
      end
      READ: begin
        issue = !cand_cmp || room;
        if (issue && rd_cnt + NPX_W'(1) == n_q)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (drained) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wdata = acc;
    strb  = '0;
    for (int k = 0; k < PX_PER_WORD; k++) begin
      if (LANE_W'(k) == ret_lane)
        wdata[k*PX_W +: PX_W] = fmo_res;
      strb[k] = (LANE_W'(k) <= ret_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q      <= '0;
      base_q   <= '0;
      rd_cnt   <= '0;
      ret_cnt  <= '0;
      wcnt     <= '0;
      rd_valid <= 1'b0;
      acc      <= '0;
    end else begin
      rd_valid <= issue;
      if (state == IDLE && start) begin
        n_q     <= n_px;
        base_q  <= base_addr;
        rd_cnt  <= '0;
        ret_cnt <= '0;
        wcnt    <= '0;
        acc     <= '0;
      end
      if (issue) rd_cnt <= rd_cnt + NPX_W'(1);
      if (rd_valid) begin
        ret_cnt <= ret_cnt + NPX_W'(1);
        acc     <= ret_cmp ? '0 : wdata;
      end
      if (ret_cmp) wcnt <= wcnt + EXT_AW'(1);
    end
  end

  assign din = '{
    addr: base_q + wcnt,
    data: wdata,
    strb: strb
  };

  fmo_wb_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret_cmp),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );

  assign ext.ext_valid = (cnt != '0);
  assign ext.ext_addr  =
    ext.ext_valid ? head.addr : '0;
  assign ext.ext_data  =
    ext.ext_valid ? head.data : '0;
  assign ext.ext_strb  =
    ext.ext_valid ? head.strb : '0;

  assign fmo_addr  = (state == READ) ?
    rd_cnt[FMO_AW-1:0] : '0;
  assign fmo_write = 1'b0;
  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_fmo_writeback.sv
// Directed table-driven bench for fmo_writeback
// with a registered-read RAM model.
module tb_fmo_writeback;
  import ram_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [EXT_AW-1:0] base_addr;
  logic [NPX_W-1:0]  n_px;
  logic [FMO_AW-1:0] fmo_addr;
  logic              fmo_write;
  logic [PX_W-1:0]   fmo_res;
  logic              busy;
  logic              done;

  fmo_writeback_if ext();

  fmo_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .n_px      (n_px),
    .fmo_addr  (fmo_addr),
    .fmo_write (fmo_write),
    .fmo_res   (fmo_res),
    .ext       (ext),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [PX_W-1:0] ram [FMO_N_ELEM];
  always @(posedge clk) fmo_res <= ram[fmo_addr];

  typedef struct {
    int          n;
    logic [31:0] base;
    int          mode;
    int          ew;
    int          edone;
    logic [63:0] ldata;
    logic [3:0]  lstrb;
    bit          restart;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;
  int vi = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h",
               nm, vi, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(int n, int w);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 4; k++)
      if (w * 4 + k < n) d[k*16 +: 16] = 16'(w * 4 + k);
    return d;
  endfunction

  function automatic logic [3:0] exp_strb(int n, int w);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 4; k++)
      s[k] = (w * 4 + k < n);
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, ext.ext_valid, 0);
    chk({tag, "_addr"}, ext.ext_addr, 0);
    chk({tag, "_data"}, ext.ext_data, 0);
    chk({tag, "_strb"}, ext.ext_strb, 0);
    chk({tag, "_fmo_addr"}, fmo_addr, 0);
    chk({tag, "_fmo_write"}, fmo_write, 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc, lim, endc, nw, ndone, dcyc;
    int bad_w, bad_stab, bad_wr, busy_dn, maxa;
    bit anz, stall;
    logic [EXT_AW+WORD_W+PX_PER_WORD:0] snap, cur;
    nw = 0; ndone = 0; dcyc = -1; bad_w = 0;
    bad_stab = 0; bad_wr = 0; busy_dn = 0;
    maxa = 0; anz = 0; stall = 0; snap = '0;
    start = 1'b1;
    n_px = NPX_W'(v.n);
    base_addr = v.base;
    ext.ext_ready = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    lim = v.n * 6 + 100;
    endc = -1;
    while (cyc < lim && (endc < 0 || cyc <= endc)) begin
      if (v.mode == 1)
        ext.ext_ready = (cyc >= 3 && cyc <= 12) ?
          1'b0 : 1'($urandom_range(0, 1));
      else
        ext.ext_ready = 1'b1;
      start = (v.restart && cyc == 5);
      if (v.restart && cyc == 5) begin
        n_px = NPX_W'(4);
        base_addr = 32'h50;
      end
      if (fmo_write !== 1'b0) bad_wr++;
      if (fmo_addr != '0) anz = 1'b1;
      if (busy && int'(fmo_addr) > maxa)
        maxa = int'(fmo_addr);
      cur = {ext.ext_valid, ext.ext_addr,
             ext.ext_data, ext.ext_strb};
      if (stall && cur !== snap) bad_stab++;
      stall = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        dcyc = cyc;
        if (busy) busy_dn++;
        if (endc < 0) endc = cyc + 3;
      end
      if (ext.ext_valid === 1'b1) begin
        if (ext.ext_ready) begin
          if (ext.ext_addr !== v.base + 32'(nw) ||
              ext.ext_data !== exp_data(v.n, nw) ||
              ext.ext_strb !== exp_strb(v.n, nw)) begin
            if (bad_w == 0)
              $display("  word %0d: addr %h data %h strb %b",
                       nw, ext.ext_addr, ext.ext_data,
                       ext.ext_strb);
            bad_w++;
          end
          if (nw == v.ew - 1) begin
            chk("last_data", ext.ext_data, v.ldata);
            chk("last_strb", ext.ext_strb, v.lstrb);
          end
          nw++;
        end else begin
          stall = 1'b1;
          snap = cur;
        end
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    chk("word_count", nw, v.ew);
    chk("word_content", bad_w, 0);
    chk("done_pulses", ndone, 1);
    chk("busy_on_done", busy_dn, 0);
    if (v.edone != 0) chk("done_cycle", dcyc, v.edone);
    chk("fmo_write", bad_wr, 0);
    chk("stall_stable", bad_stab, 0);
    if (v.n > 0) chk("last_rd_addr", maxa, v.n - 1);
    else         chk("addr_moved", anz, 0);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < FMO_N_ELEM; i++) ram[i] = 16'(i);
    reset = 1'b1;
    start = 1'b0;
    n_px = '0;
    base_addr = '0;
    ext.ext_ready = 1'b0;
    tick;
    tick;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick;

    vecs[0] = '{8, 32'h100, 0, 2, 11,
                64'h0007_0006_0005_0004, 4'hF, 0};
    vecs[1] = '{6, 32'h200, 0, 2, 9,
                64'h0000_0000_0005_0004, 4'h3, 0};
    vecs[2] = '{0, 32'h300, 0, 0, 1,
                64'h0, 4'h0, 0};
    vecs[3] = '{16, 32'h400, 1, 4, 0,
                64'h000F_000E_000D_000C, 4'hF, 0};
    vecs[4] = '{1, 32'h500, 0, 1, 4,
                64'h0, 4'h1, 0};
    vecs[5] = '{5, 32'hFFFF_FFFF, 0, 2, 8,
                64'h0000_0000_0000_0004, 4'h1, 0};
    vecs[6] = '{1024, 32'hFFFF_FFFF, 0, 256, 1027,
                64'h03FF_03FE_03FD_03FC, 4'hF, 1};

    for (int i = 0; i < 7; i++) begin
      vi = i;
      run_xfer(vecs[i]);
      tick;
    end

    // Abort an n_px=16 transfer with reset at cycle 5.
    vi = 100;
    start = 1'b1;
    n_px = NPX_W'(16);
    base_addr = 32'h700;
    ext.ext_ready = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    tick;
    check_reset_outputs("midrst");
    reset = 1'b0;
    nd = 0;
    repeat (5) begin
      if (done) nd++;
      tick;
    end
    chk("no_done_after_reset", nd, 0);

    vi = 101;
    run_xfer('{16, 32'h800, 0, 4, 19,
               64'h000F_000E_000D_000C, 4'hF, 0});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
